// File: rtl/right_shift_unit.sv
// right_shift_unit: sequential right-shift engine.
// Shifts one WIDTH-bit operand right by one bit per clock in logical,
// arithmetic or rotate mode. It returns the shifted result and the last
// bit shifted out.
//
// State table
//   state | meaning
//   IDLE  | waiting for a request, in_ready=1
//   SHIFT | shifting one bit per cycle, cnt holds the remaining count
//   DONE  | result valid on r/cout, held until out_ready
//
// Ports
//   clk        sole clock
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   block can accept a request (state==IDLE)
//   a          operand, sampled on accept
//   amt        shift count 0..WIDTH-1, sampled on accept
//   mode       00 logical, 01 arithmetic, 10 rotate, 11 logical
//   out_valid  result valid (state==DONE)
//   out_ready  consumer takes the result
//   r          result (shift register, intermediate values during SHIFT)
//   cout       last bit shifted out, 0 when amt==0
//   busy       state!=IDLE
module right_shift_unit #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   amt,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_shifted;
    logic [SHW-1:0]   cnt;
    logic [1:0]       md;
    logic             cout_q;
    logic             fill;
    logic             accept;

    assign accept = in_valid && in_ready;

    // Bit entering at the MSB. Mode 11 falls into the default and
    // therefore behaves exactly as logical.
    always_comb begin
        fill = 1'b0;
        case (md)
            2'b01:   fill = sh[WIDTH-1];
            2'b10:   fill = sh[0];
            default: fill = 1'b0;
        endcase
        sh_shifted = {fill, sh[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt == SHW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh     <= '0;
            cnt    <= '0;
            md     <= 2'b00;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh     <= a;
                        cnt    <= amt;
                        md     <= mode;
                        cout_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    sh     <= sh_shifted;
                    cout_q <= sh[0];
                    cnt    <= cnt - SHW'(1);
                end
                default: ;
            endcase
        end
    end

    assign r    = sh;
    assign cout = cout_q;

endmodule

// File: tb/tb_right_shift_unit.sv
module tb_right_shift_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [2:0] amt;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] r;
    logic       cout;
    logic       busy;

    int n_vec  = 0;
    int n_fail = 0;
    int n_acc  = 0;
    int n_hand = 0;

    right_shift_unit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .amt       (amt),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [2:0] amt;
        logic [1:0] mode;
        logic [7:0] exp_r;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // Reference built from wide shifts, independent of the bit-serial RTL.
    function automatic logic [8:0] ref_model(input logic [7:0] x, input logic [2:0] n,
                                             input logic [1:0] m);
        logic [15:0] t;
        logic        c;
        case (m)
            2'b01:   t = {{8{x[7]}}, x} >> n;
            2'b10:   t = {x, x} >> n;
            default: t = {8'h00, x} >> n;
        endcase
        c = (n == 3'd0) ? 1'b0 : x[int'(n) - 1];
        return {c, t[7:0]};
    endfunction

    // Exclusivity and transfer counting, sampled at the active edge.
    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) n_acc++;
            if (out_valid && out_ready) n_hand++;
        end
    end

    always @(negedge clk) begin
        if (in_ready && out_valid) begin
            n_fail++;
            $display("FAIL exclusivity: in_ready=1 out_valid=1 required not both");
        end
    end

    // Issue one request, wait for the result, hold out_ready low for
    // 'stall' cycles, then hand off. Returns result and latency.
    task automatic run_op(input logic [7:0] xa, input logic [2:0] xn, input logic [1:0] xm,
                          input int stall, output logic [7:0] got_r, output logic got_c,
                          output int lat);
        int budget;
        got_r = 8'h00;
        got_c = 1'b0;
        lat   = 0;
        @(negedge clk);
        budget = 0;
        while (!in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        a        = xa;
        amt      = xn;
        mode     = xm;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 8'h00;
        amt      = 3'd0;
        mode     = 2'b00;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) begin
            check("out_valid_timeout", 0, 1);
            return;
        end
        got_r = r;
        got_c = cout;
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] gr;
        logic       gc;
        logic [8:0] m;
        int         lat;
        int         acc0;
        int         hand0;

        vecs[0] = '{8'hB5, 3'd3, 2'b00, 8'h16, 1'b1};
        vecs[1] = '{8'hB5, 3'd3, 2'b01, 8'hF6, 1'b1};
        vecs[2] = '{8'hB5, 3'd3, 2'b10, 8'hB6, 1'b1};
        vecs[3] = '{8'hB5, 3'd3, 2'b11, 8'h16, 1'b1};
        vecs[4] = '{8'h81, 3'd0, 2'b00, 8'h81, 1'b0};
        vecs[5] = '{8'h80, 3'd7, 2'b00, 8'h01, 1'b0};
        vecs[6] = '{8'hFF, 3'd7, 2'b01, 8'hFF, 1'b1};
        vecs[7] = '{8'h3C, 3'd0, 2'b10, 8'h3C, 1'b0};
        vecs[8] = '{8'h7F, 3'd2, 2'b01, 8'h1F, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 8'h00;
        amt       = 3'd0;
        mode      = 2'b00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_r", int'(r), 0);
        check("rst_cout", int'(cout), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].amt, vecs[i].mode, 0, gr, gc, lat);
            check($sformatf("vec%0d_r", i), int'(gr), int'(vecs[i].exp_r));
            check($sformatf("vec%0d_cout", i), int'(gc), int'(vecs[i].exp_cout));
            check($sformatf("vec%0d_latency", i), lat, int'(vecs[i].amt) + 1);
            @(negedge clk);
            check($sformatf("vec%0d_in_ready_after", i), int'(in_ready), 1);
        end

        // Backpressure: result held, new request ignored.
        @(negedge clk);
        in_valid = 1'b1; a = 8'hB5; amt = 3'd3; mode = 2'b01;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("bp_out_valid", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_valid = 1'b1; a = 8'h0F; amt = 3'd1; mode = 2'b00;
            end
            if (i == 3) in_valid = 1'b0;
            @(negedge clk);
            check("bp_r_stable", int'(r), 8'hF6);
            check("bp_cout_stable", int'(cout), 1);
            check("bp_out_valid_stable", int'(out_valid), 1);
            check("bp_in_ready_low", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_idle_after", int'(in_ready), 1);
        repeat (3) @(negedge clk);
        check("bp_no_ghost_busy", int'(busy), 0);
        check("bp_no_ghost_valid", int'(out_valid), 0);

        // Reset in the middle of a shift.
        @(negedge clk);
        in_valid = 1'b1; a = 8'hF0; amt = 3'd6; mode = 2'b00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid_busy_before_rst", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_r", int'(r), 0);
        check("mid_rst_cout", int'(cout), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h0F, 3'd1, 2'b00, 0, gr, gc, lat);
        check("post_rst_r", int'(gr), 8'h07);
        check("post_rst_cout", int'(gc), 1);

        // Random stream with consumer stalls.
        @(negedge clk);
        acc0  = n_acc;
        hand0 = n_hand;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] xa;
            logic [2:0] xn;
            logic [1:0] xm;
            xa = 8'($urandom);
            xn = 3'($urandom_range(0, 7));
            xm = 2'($urandom_range(0, 3));
            m  = ref_model(xa, xn, xm);
            run_op(xa, xn, xm, $urandom_range(0, 3), gr, gc, lat);
            check($sformatf("rnd%0d_r", i), int'(gr), int'(m[7:0]));
            check($sformatf("rnd%0d_cout", i), int'(gc), int'(m[8]));
            check($sformatf("rnd%0d_latency", i), lat, int'(xn) + 1);
        end
        @(negedge clk);
        check("stream_accepts", n_acc - acc0, 20);
        check("stream_handoffs", n_hand - hand0, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
